// File: rtl/alu_sched.sv
// alu_sched: two-port round-robin request scheduler and sequencer for the
// 8-bit multi-cycle ALU (add/sub/mul/div).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/ready           request handshake, one pair per requester
//   reqN_op/opa/opb            operation, first operand (A:Q for div), operand M
//   rsp_valid/ready            response handshake
//   rsp_id/data/err            requester index, captured ALU outbus, watchdog flag
//   alu_start/sel/inbus/rst    ALU loading protocol outputs (alu_rst active-high)
//   alu_outbus/finish          ALU result and done
//   busy                       high in every state except IDLE
//
// Optional feature: define ALU_SCHED_TIMEOUT_EN to compile in a RUN-state
// watchdog that aborts after TIMEOUT_CYC cycles with rsp_err=1, rsp_data=0.
module alu_sched #(
    parameter int OP2_DELAY   = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_opa,
    input  logic [7:0]  req0_opb,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_opa,
    input  logic [7:0]  req1_opb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        alu_start,
    output logic [1:0]  alu_sel,
    output logic [15:0] alu_inbus,
    output logic        alu_rst,
    input  logic [15:0] alu_outbus,
    input  logic        alu_finish,
    output logic        busy
);

    localparam int CW = 16;
    localparam logic [CW-1:0] LOAD_LAST = CW'(OP2_DELAY - 1);

    if (OP2_DELAY < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("alu_sched: OP2_DELAY and TIMEOUT_CYC must be >= 1");
    end

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_START, S_LOAD, S_RUN, S_RESP
    } state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] opa;
        logic [7:0]  opb;
        logic        id;
    } req_t;

    state_t        state, state_nx;
    req_t          cur;
    logic          last_grant;
    logic          gnt_vld, gnt_id;
    logic [CW-1:0] cnt;
    logic          hs, done, timeout;

    // Grant is registered so ready never depends combinationally on valid.
    // It is recomputed every cycle; a requester holds valid until accepted,
    // so the grant seen in IDLE always matches a still-pending request.
    assign req0_ready = (state == S_IDLE) && gnt_vld && !gnt_id;
    assign req1_ready = (state == S_IDLE) && gnt_vld &&  gnt_id;
    assign hs         = (state == S_IDLE) && gnt_vld && (gnt_id ? req1_valid : req0_valid);

    assign done = (state == S_RUN) && alu_finish;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam logic [CW-1:0] RUN_LAST = CW'(TIMEOUT_CYC - 1);
    logic rsp_err_q;

    assign timeout = (state == S_RUN) && !alu_finish && (cnt == RUN_LAST);
    assign rsp_err = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rsp_err_q <= 1'b0;
        else if (done)    rsp_err_q <= 1'b0;
        else if (timeout) rsp_err_q <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        alu_start = 1'b0;
        alu_sel   = 2'b00;
        alu_inbus = 16'h0000;
        case (state)
            S_CLEAR: state_nx = S_IDLE;
            S_IDLE:  if (hs) state_nx = S_START;
            S_START: begin
                alu_start = 1'b1;
                alu_sel   = cur.op;
                alu_inbus = cur.opa;
                state_nx  = S_LOAD;
            end
            S_LOAD: begin
                alu_sel   = cur.op;
                alu_inbus = cur.opa;
                if (cnt == LOAD_LAST) state_nx = S_RUN;
            end
            S_RUN: begin
                alu_sel   = cur.op;
                alu_inbus = {8'h00, cur.opb};
                if (done || timeout) state_nx = S_RESP;
            end
            S_RESP:  if (rsp_ready) state_nx = S_CLEAR;
            default: state_nx = S_CLEAR;
        endcase
    end

    assign alu_rst   = (state == S_CLEAR);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_id    = cur.id;

    // Shared LOAD/RUN cycle counter, cleared on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                cnt <= '0;
        else if (state_nx != state)                cnt <= '0;
        else if (state == S_LOAD || state == S_RUN) cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            last_grant <= 1'b1;
            gnt_vld    <= 1'b0;
            gnt_id     <= 1'b0;
            cur        <= '0;
            rsp_data   <= 16'h0000;
        end else begin
            state   <= state_nx;
            gnt_vld <= req0_valid | req1_valid;
            gnt_id  <= (req0_valid && req1_valid) ? ~last_grant : req1_valid;
            if (hs) begin
                cur        <= gnt_id ? {req1_op, req1_opa, req1_opb, 1'b1}
                                     : {req0_op, req0_opa, req0_opb, 1'b0};
                last_grant <= gnt_id;
            end
            if (done)         rsp_data <= alu_outbus;
            else if (timeout) rsp_data <= 16'h0000;
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed bench for alu_sched with a behavioural ALU and a
// cycle-timeline reference model checked on every falling clock edge.
module tb_alu_sched;

    localparam int D = 2;
    localparam int T = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [15:0] req0_opa, req1_opa;
    logic [7:0]  req0_opb, req1_opb;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_data;
    logic        alu_start, alu_rst, alu_finish, busy;
    logic [1:0]  alu_sel;
    logic [15:0] alu_inbus, alu_outbus;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_sched #(.OP2_DELAY(D), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_opa(req0_opa), .req0_opb(req0_opb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_opa(req1_opa), .req1_opb(req1_opb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_start(alu_start), .alu_sel(alu_sel), .alu_inbus(alu_inbus),
        .alu_rst(alu_rst), .alu_outbus(alu_outbus), .alu_finish(alu_finish),
        .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result an 8-bit ALU produces: add keeps the carry in bit 8, sub is
    // 8-bit, mul is the 16-bit product, div returns {remainder, quotient}.
    function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [15:0] a,
                                            input logic [7:0] m);
        case (op)
            2'd0:    alu_ref = 16'(a[7:0]) + 16'(m);
            2'd1:    alu_ref = {8'h00, 8'(a[7:0] - m)};
            2'd2:    alu_ref = 16'(a[7:0]) * 16'(m);
            default: alu_ref = (m == 8'h00) ? 16'hFFFF : {8'(a % 16'(m)), 8'(a / 16'(m))};
        endcase
    endfunction

    function automatic int alu_lat(input logic [1:0] op);
        case (op)
            2'd0, 2'd1: alu_lat = 3;
            2'd2:       alu_lat = 6;
            default:    alu_lat = 9;
        endcase
    endfunction

    // Behavioural ALU: A on the start cycle, M sampled in the first cycle
    // after the OP2_DELAY hold, finish raised after a per-op latency and held
    // until the next ALU reset.
    logic [15:0] a_q;
    logic [7:0]  m_q;
    logic [1:0]  sel_q;
    int          acnt;
    logic        active;
    logic        stub_hang = 1'b0;

    always @(posedge clk) begin
        if (alu_rst) begin
            active     <= 1'b0;
            acnt       <= 0;
            alu_finish <= 1'b0;
            alu_outbus <= 16'h0000;
        end else if (alu_start) begin
            active <= 1'b1;
            a_q    <= alu_inbus;
            sel_q  <= alu_sel;
            acnt   <= 1;
        end else if (active) begin
            acnt <= acnt + 1;
            if (acnt == D + 1) m_q <= alu_inbus[7:0];
            if (acnt == D + 1 + alu_lat(sel_q) && !stub_hang) begin
                alu_finish <= 1'b1;
                alu_outbus <= alu_ref(sel_q, a_q, m_q);
            end
        end
    end

    // Reference timeline: cycles counted from reset release; a handshake at
    // cycle h puts START at h+1, LOAD at h+2..h+1+D, RUN from h+2+D.
    int          m_cyc, m_idle_from, m_hs, m_resp_from, ph;
    bit          m_inflight, m_resp_known, m_prev_rst = 1'b1, m_last = 1'b1;
    logic [1:0]  m_op;
    logic [15:0] m_opa, m_data;
    logic [7:0]  m_opb;
    logic        m_id, m_err;
    bit          e_idle, e_rst, e_start, e_rv, p;
    logic [1:0]  e_sel;
    logic [15:0] e_inbus;
    int          n_rsp = 0;
    logic [15:0] log_data[0:63];
    logic        log_id[0:63];
    logic        log_err[0:63];

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_alu_rst", alu_rst, 1);
            chk("rst_busy", busy, 1);
            chk("rst_outs", {rsp_valid, req0_ready, req1_ready, alu_start, alu_sel, alu_inbus}, 0);
            m_inflight = 0; m_resp_known = 0; m_last = 1; m_prev_rst = 1;
        end else begin
            if (m_prev_rst) begin m_cyc = 0; m_idle_from = 1; end
            else m_cyc++;
            m_prev_rst = 0;

            e_rst = (m_cyc == m_idle_from - 1);
            e_idle = !m_inflight && m_cyc >= m_idle_from;
            e_start = 0; e_sel = 2'b00; e_inbus = 16'h0000; e_rv = 0;
            if (m_inflight) begin
                ph = m_cyc - m_hs;
                if (m_resp_known && m_cyc >= m_resp_from) e_rv = 1;
                else if (ph == 1) begin e_start = 1; e_sel = m_op; e_inbus = m_opa; end
                else if (ph >= 2 && ph <= 1 + D) begin e_sel = m_op; e_inbus = m_opa; end
                else if (ph >= 2 + D) begin e_sel = m_op; e_inbus = {8'h00, m_opb}; end
            end

            chk("alu_rst", alu_rst, e_rst);
            chk("busy", busy, !e_idle);
            chk("alu_start", alu_start, e_start);
            chk("alu_sel", alu_sel, e_sel);
            chk("alu_inbus", alu_inbus, e_inbus);
            chk("rsp_valid", rsp_valid, e_rv);
            if (e_rv) chk("rsp_fields", {rsp_err, rsp_id, rsp_data}, {m_err, m_id, m_data});
            if (!e_idle) chk("ready_busy", {req0_ready, req1_ready}, 0);
            else begin
                chk("ready_onehot", req0_ready & req1_ready, 0);
                chk("arb0", req0_ready & !(req0_valid & (!req1_valid | m_last)), 0);
                chk("arb1", req1_ready & !(req1_valid & (!req0_valid | !m_last)), 0);
            end

            if (e_idle && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
                p = req1_valid && req1_ready;
                m_id  = p;
                m_op  = p ? req1_op  : req0_op;
                m_opa = p ? req1_opa : req0_opa;
                m_opb = p ? req1_opb : req0_opb;
                m_data = alu_ref(m_op, m_opa, m_opb);
                m_err = 0; m_last = p; m_hs = m_cyc;
                m_inflight = 1; m_resp_known = 0;
            end else if (m_inflight && !m_resp_known && (m_cyc - m_hs) >= 2 + D && alu_finish) begin
                m_resp_known = 1; m_resp_from = m_cyc + 1;
`ifdef ALU_SCHED_TIMEOUT_EN
            end else if (m_inflight && !m_resp_known && (m_cyc - m_hs) == 1 + D + T) begin
                m_resp_known = 1; m_resp_from = m_cyc + 1; m_err = 1; m_data = 16'h0000;
`endif
            end
            if (e_rv && rsp_ready) begin
                if (n_rsp < 64) begin
                    log_data[n_rsp] = rsp_data; log_id[n_rsp] = rsp_id; log_err[n_rsp] = rsp_err;
                end
                n_rsp++;
                m_inflight = 0; m_resp_known = 0; m_idle_from = m_cyc + 2;
            end
        end
    end

    // Presents requests on the enabled ports and drops each valid right after
    // its accepting edge; returns once every enabled request was taken.
    task automatic send(input bit e0, input bit e1,
                        input logic [1:0] op0, input logic [15:0] a0, input logic [7:0] b0,
                        input logic [1:0] op1, input logic [15:0] a1, input logic [7:0] b1);
        bit h0, h1;
        req0_op = op0; req0_opa = a0; req0_opb = b0;
        req1_op = op1; req1_opa = a1; req1_opb = b1;
        req0_valid = e0; req1_valid = e1;
        for (int i = 0; i < 300 && (req0_valid || req1_valid); i++) begin
            @(negedge clk);
            h0 = req0_valid && req0_ready;
            h1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (h0) req0_valid = 1'b0;
            if (h1) req1_valid = 1'b0;
        end
        chk("accept_timeout", {req0_valid, req1_valid}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 500 && n_rsp < target; i++) begin
            @(posedge clk); #1;
        end
        chk("rsp_timeout", n_rsp >= target, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int          k, n_saved;
    logic [15:0] held;

    initial begin
        rst_n = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'b00; req0_opa = 16'h0; req0_opb = 8'h0;
        req1_op = 2'b00; req1_opa = 16'h0; req1_opb = 8'h0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_data", rsp_data, 16'h0000);
        chk("reset_alu_rst", alu_rst, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk("clear_after_rst", alu_rst, 1);
        @(negedge clk); chk("idle_after_clear", {alu_rst, busy}, 0);
        @(posedge clk); #1;

        // add / sub / mul / div
        send(1, 0, 2'd0, 16'd40, 8'd12, 2'd0, 16'd0, 8'd0);
        wait_rsp(1); k = n_rsp - 1;
        chk("add_data", log_data[k], 16'h0034);
        chk("add_id_err", {log_id[k], log_err[k]}, 2'b00);
        send(0, 1, 2'd0, 16'd0, 8'd0, 2'd1, 16'd40, 8'd12);
        wait_rsp(2); k = n_rsp - 1;
        chk("sub_data", log_data[k], 16'h001C);
        chk("sub_id", log_id[k], 1);
        send(0, 1, 2'd0, 16'd0, 8'd0, 2'd2, 16'd40, 8'd12);
        wait_rsp(3); k = n_rsp - 1;
        chk("mul_data", log_data[k], 16'h01E0);
        send(1, 0, 2'd3, 16'd11542, 8'd135, 2'd0, 16'd0, 8'd0);
        wait_rsp(4); k = n_rsp - 1;
        chk("div_data", log_data[k], 16'h4355);

        // arbitration: tie after reset goes to req0, then alternation
        pulse_reset();
        send(1, 1, 2'd0, 16'd5, 8'd6, 2'd1, 16'd9, 8'd4);
        wait_rsp(6); k = n_rsp - 2;
        chk("tie1_order", {log_id[k], log_id[k+1]}, 2'b01);
        chk("tie1_data", {log_data[k], log_data[k+1]}, {16'h000B, 16'h0005});
        send(1, 1, 2'd2, 16'd3, 8'd4, 2'd0, 16'd1, 8'd1);
        wait_rsp(8); k = n_rsp - 2;
        chk("tie2_order", {log_id[k], log_id[k+1]}, 2'b01);

        // back-pressure with a competing request waiting
        rsp_ready = 1'b0;
        send(1, 0, 2'd2, 16'd7, 8'd9, 2'd0, 16'd0, 8'd0);
        for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
        chk("bp_rsp_seen", rsp_valid, 1);
        held = rsp_data;
        chk("bp_data_val", held, 16'h003F);
        @(posedge clk); #1;
        req1_op = 2'd1; req1_opa = 16'd50; req1_opb = 8'd8; req1_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {rsp_valid, rsp_data, req1_ready}, {1'b1, held, 1'b0});
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        send(0, 1, 2'd0, 16'd0, 8'd0, 2'd1, 16'd50, 8'd8);
        wait_rsp(10); k = n_rsp - 1;
        chk("bp_next_data", {log_id[k], log_data[k]}, {1'b1, 16'h002A});

        // reset mid-RUN discards the operation
        send(1, 0, 2'd3, 16'd1000, 8'd7, 2'd0, 16'd0, 8'd0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrun_rst", {alu_rst, rsp_valid}, 2'b10);
        n_saved = n_rsp;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("midrun_no_rsp", n_rsp, n_saved);
        send(0, 1, 2'd0, 16'd0, 8'd0, 2'd0, 16'd100, 8'd200);
        wait_rsp(n_saved + 1); k = n_rsp - 1;
        chk("after_rst_data", {log_id[k], log_err[k], log_data[k]}, {2'b10, 16'h012C});

`ifdef ALU_SCHED_TIMEOUT_EN
        stub_hang = 1'b1;
        n_saved = n_rsp;
        send(1, 0, 2'd0, 16'd1, 8'd2, 2'd0, 16'd0, 8'd0);
        wait_rsp(n_saved + 1); k = n_rsp - 1;
        chk("timeout_rsp", {log_err[k], log_data[k]}, {1'b1, 16'h0000});
        stub_hang = 1'b0;
        send(0, 1, 2'd0, 16'd0, 8'd0, 2'd1, 16'd9, 8'd3);
        wait_rsp(n_saved + 2); k = n_rsp - 1;
        chk("after_timeout", {log_err[k], log_data[k]}, {1'b0, 16'h0006});
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
